// File: rtl/ram32x4_hex_pkg.sv
// Shared constants and the hex-to-7-segment decoder for the switch-driven RAM board block.
package ram_hex_pkg;

    // Default geometry of the RAM behind the switches.
    localparam int DEF_DATA_W      = 4;
    localparam int DEF_ADDR_W      = 5;
    localparam int DEF_SYNC_STAGES = 2;

    // Switch bank: {write enable, address, data}.
    localparam int SW_W = 1 + DEF_ADDR_W + DEF_DATA_W;

    // All segments off (display outputs are active-low).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segment pattern, bit order g f e d c b a.
    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ram32x4_hex_if.sv
// Board-side bundle: slide switches in, six 7-segment digits out.
interface ram32x4_hex_if;
    import ram_hex_pkg::*;

    logic [SW_W-1:0] sw;
    logic [6:0]      hex0;
    logic [6:0]      hex1;
    logic [6:0]      hex2;
    logic [6:0]      hex3;
    logic [6:0]      hex4;
    logic [6:0]      hex5;

    // Board / stimulus side: drives switches, watches displays.
    modport master (
        output sw,
        input  hex0, hex1, hex2, hex3, hex4, hex5
    );

    // Design side: reads switches, drives displays.
    modport slave (
        input  sw,
        output hex0, hex1, hex2, hex3, hex4, hex5
    );
endinterface

// File: rtl/ram32x4_hex_sync.sv
// Multi-stage flip-flop chain that brings asynchronous switch levels into the clk domain.
module sync_chain #(
    parameter int BITS   = 1,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] raw,
    output logic [BITS-1:0] clean
);

    logic [BITS-1:0] stage_q [STAGES];
    logic [BITS-1:0] stage_d [STAGES];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            // First stage samples the raw asynchronous input.
            always_comb stage_d[gi] = raw;
        end else begin : g_rest
            // Later stages shift the previous stage forward.
            always_comb stage_d[gi] = stage_q[gi-1];
        end

        // Stage register, cleared by reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                stage_q[gi] <= '0;
            end else begin
                stage_q[gi] <= stage_d[gi];
            end
        end
    end

    assign clean = stage_q[STAGES-1];

endmodule

// File: rtl/ram32x4_hex_top.sv
// Switch-driven single-port RAM with write-first registered read and hex display of
// address, data-in and data-out.
module ram32x4_hex_top
    import ram_hex_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic          clk,
    input  logic          reset,
    ram32x4_hex_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;

    sync_chain #(.BITS(1), .STAGES(SYNC_STAGES)) u_sync_wr (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.sw[DATA_W+ADDR_W]),
        .clean (wr)
    );

    sync_chain #(.BITS(ADDR_W), .STAGES(SYNC_STAGES)) u_sync_addr (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.sw[DATA_W +: ADDR_W]),
        .clean (addr)
    );

    sync_chain #(.BITS(DATA_W), .STAGES(SYNC_STAGES)) u_sync_din (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.sw[DATA_W-1:0]),
        .clean (din)
    );

    // Array starts at zero from the configuration image; reset never touches it.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              wr_en;

    // Write-first read data; a write still in the synchroniser when reset arrives is dropped.
    always_comb begin
        wr_en  = wr & ~reset;
        dout_d = wr ? din : mem_q[addr];
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= din;
        end
    end

    // Registered read output, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    logic [7:0] addr_ext;
    logic [3:0] din_ext;
    logic [3:0] dout_ext;

    // Zero-extend the fields to whole nibbles for the digit decoders.
    always_comb begin
        addr_ext = 8'(addr);
        din_ext  = 4'(din);
        dout_ext = 4'(dout_q);
    end

    assign bus.hex0 = seg7_encode(dout_ext);
    assign bus.hex1 = SEG_BLANK;
    assign bus.hex2 = seg7_encode(din_ext);
    assign bus.hex3 = SEG_BLANK;
    assign bus.hex4 = seg7_encode(addr_ext[3:0]);
    assign bus.hex5 = seg7_encode(addr_ext[7:4]);

endmodule

// File: tb/tb_ram32x4_hex_top.sv
// Directed bench for the switch-driven RAM: reset state, write-first latency, readback,
// untouched words and reset arriving during a write.
module tb_ram32x4_hex_top;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SBLANK = 7'b1111111;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ram32x4_hex_if bus ();

    ram32x4_hex_top dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_sw(input logic w, input logic [4:0] a, input logic [3:0] d);
        bus.sw = {w, a, d};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_sw(1'b0, 5'h00, 4'h0);
        repeat (2) @(negedge clk);
        checks++; if (bus.hex0 !== S0) begin errors++; $display("FAIL reset_hex0 got %b exp %b", bus.hex0, S0); end
        checks++; if (bus.hex1 !== SBLANK) begin errors++; $display("FAIL reset_hex1 got %b exp %b", bus.hex1, SBLANK); end
        checks++; if (bus.hex2 !== S0) begin errors++; $display("FAIL reset_hex2 got %b exp %b", bus.hex2, S0); end
        checks++; if (bus.hex3 !== SBLANK) begin errors++; $display("FAIL reset_hex3 got %b exp %b", bus.hex3, SBLANK); end
        checks++; if (bus.hex4 !== S0) begin errors++; $display("FAIL reset_hex4 got %b exp %b", bus.hex4, S0); end
        checks++; if (bus.hex5 !== S0) begin errors++; $display("FAIL reset_hex5 got %b exp %b", bus.hex5, S0); end
        $display("reset: hex0=%b hex1=%b hex2=%b hex4=%b hex5=%b", bus.hex0, bus.hex1, bus.hex2, bus.hex4, bus.hex5);
        reset = 1'b0;
    endtask

    task automatic test_write_addr0();
        set_sw(1'b1, 5'h00, 4'h1);
        @(negedge clk);
        set_sw(1'b0, 5'h00, 4'h1);
        @(negedge clk);
        checks++; if (bus.hex2 !== S1) begin errors++; $display("FAIL w0_hex2 got %b exp %b", bus.hex2, S1); end
        @(negedge clk);
        checks++; if (bus.hex0 !== S1) begin errors++; $display("FAIL w0_hex0_first got %b exp %b", bus.hex0, S1); end
        repeat (2) @(negedge clk);
        checks++; if (bus.hex0 !== S1) begin errors++; $display("FAIL w0_hex0_read got %b exp %b", bus.hex0, S1); end
        checks++; if (bus.hex4 !== S0) begin errors++; $display("FAIL w0_hex4 got %b exp %b", bus.hex4, S0); end
        checks++; if (bus.hex5 !== S0) begin errors++; $display("FAIL w0_hex5 got %b exp %b", bus.hex5, S0); end
        $display("write a=00 d=1: hex0=%b hex4=%b hex5=%b", bus.hex0, bus.hex4, bus.hex5);
    endtask

    task automatic test_write_addr9();
        set_sw(1'b1, 5'h09, 4'hF);
        @(negedge clk);
        set_sw(1'b0, 5'h09, 4'hF);
        @(negedge clk);
        checks++; if (bus.hex4 !== S9) begin errors++; $display("FAIL w9_hex4 got %b exp %b", bus.hex4, S9); end
        checks++; if (bus.hex5 !== S0) begin errors++; $display("FAIL w9_hex5 got %b exp %b", bus.hex5, S0); end
        checks++; if (bus.hex2 !== SF) begin errors++; $display("FAIL w9_hex2 got %b exp %b", bus.hex2, SF); end
        @(negedge clk);
        checks++; if (bus.hex0 !== SF) begin errors++; $display("FAIL w9_hex0_first got %b exp %b", bus.hex0, SF); end
        $display("write a=09 d=F: hex0=%b hex2=%b hex4=%b", bus.hex0, bus.hex2, bus.hex4);
    endtask

    task automatic test_readback();
        set_sw(1'b0, 5'h00, 4'hF);
        repeat (3) @(negedge clk);
        checks++; if (bus.hex0 !== S1) begin errors++; $display("FAIL rb0_hex0 got %b exp %b", bus.hex0, S1); end
        $display("read a=00: hex0=%b", bus.hex0);
        set_sw(1'b0, 5'h09, 4'h0);
        repeat (3) @(negedge clk);
        checks++; if (bus.hex0 !== SF) begin errors++; $display("FAIL rb9_hex0 got %b exp %b", bus.hex0, SF); end
        $display("read a=09: hex0=%b", bus.hex0);
    endtask

    task automatic test_rewrite_unwritten();
        set_sw(1'b1, 5'h00, 4'hA);
        @(negedge clk);
        set_sw(1'b0, 5'h00, 4'hA);
        repeat (4) @(negedge clk);
        checks++; if (bus.hex0 !== SA) begin errors++; $display("FAIL rw0_hex0 got %b exp %b", bus.hex0, SA); end
        $display("rewrite a=00 d=A: hex0=%b", bus.hex0);
        set_sw(1'b0, 5'h1F, 4'h0);
        repeat (2) @(negedge clk);
        checks++; if (bus.hex5 !== S1) begin errors++; $display("FAIL r1f_hex5 got %b exp %b", bus.hex5, S1); end
        checks++; if (bus.hex4 !== SF) begin errors++; $display("FAIL r1f_hex4 got %b exp %b", bus.hex4, SF); end
        @(negedge clk);
        checks++; if (bus.hex0 !== S0) begin errors++; $display("FAIL r1f_hex0 got %b exp %b", bus.hex0, S0); end
        $display("read a=1F: hex0=%b hex4=%b hex5=%b", bus.hex0, bus.hex4, bus.hex5);
    endtask

    task automatic test_reset_mid_write();
        set_sw(1'b1, 5'h03, 4'h7);
        repeat (2) @(negedge clk);
        // Clean wr is high now; reset lands on the edge that would perform the write.
        reset = 1'b1;
        set_sw(1'b0, 5'h03, 4'h0);
        repeat (2) @(negedge clk);
        checks++; if (bus.hex0 !== S0) begin errors++; $display("FAIL rst_mid_hex0 got %b exp %b", bus.hex0, S0); end
        checks++; if (bus.hex4 !== S0) begin errors++; $display("FAIL rst_mid_hex4 got %b exp %b", bus.hex4, S0); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.hex4 !== S3) begin errors++; $display("FAIL post_rst_hex4 got %b exp %b", bus.hex4, S3); end
        checks++; if (bus.hex0 !== S0) begin errors++; $display("FAIL mem3_hex0 got %b exp %b", bus.hex0, S0); end
        $display("reset mid-write a=03: hex0=%b hex4=%b", bus.hex0, bus.hex4);
        set_sw(1'b0, 5'h00, 4'h0);
        repeat (3) @(negedge clk);
        checks++; if (bus.hex0 !== SA) begin errors++; $display("FAIL mem0_kept_hex0 got %b exp %b", bus.hex0, SA); end
        $display("read a=00 after reset: hex0=%b", bus.hex0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.sw = '0;
        @(negedge clk);
        test_reset();
        test_write_addr0();
        test_write_addr9();
        test_readback();
        test_rewrite_unwritten();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
